// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester front end sharing one 3-bit ALU (add/sub/mul/rem).
// It grants one requester at a time, latches that requester's operands, and
// evaluates the ALU on the latched operands. The registered result and flags
// are then held on a response handshake until the granted requester takes them.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid[1:0]          per-requester operation pending
//   req_ready[1:0]          per-requester acceptance strobe (one-hot or zero)
//   req0_num1/num2/sel      requester 0 operands (3/3/2 bits)
//   req1_num1/num2/sel      requester 1 operands (3/3/2 bits)
//   rsp_valid[1:0]          result available for requester i (one-hot or zero)
//   rsp_ready[1:0]          requester i consumes the result
//   rsp_result[4:0]         registered ALU result
//   rsp_zero, rsp_divz      registered zero / remainder-by-zero flags
//   busy                    an operation is in flight
//   op_count[7:0]           completed operations, wraps at 255
//
// Build option: ALU_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins
// every conflict, no last-grant pointer). It is undefined by default, which
// gives round-robin arbitration.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [2:0] req0_num1,
  input  logic [2:0] req0_num2,
  input  logic [1:0] req0_sel,
  input  logic [2:0] req1_num1,
  input  logic [2:0] req1_num2,
  input  logic [1:0] req1_sel,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [4:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_divz,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int DATA_W = 3;
  localparam int RES_W  = 5;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic                gnt_p0;
  logic [DATA_W-1:0]   num1_p0;
  logic [DATA_W-1:0]   num2_p0;
  logic [1:0]          sel_p0;
  logic                grant;
  logic                accept;
  logic [RES_W+1:0]    alu_out;
`ifndef ALU_ARB_FIXED_PRI_EN
  logic                last_p0;
`endif

  // ALU behaviour: 5-bit wrap-around add/sub/mul. A remainder by zero
  // returns 0 and raises divz. The result is packed as {result, zero, divz}.
  function automatic logic [RES_W+1:0] alu_calc(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [1:0]        sel);
    logic [RES_W-1:0]    r;
    logic [2*DATA_W-1:0] prod;
    logic                dz;
    r    = '0;
    dz   = 1'b0;
    prod = {3'b000, a} * {3'b000, b};
    unique case (sel)
      2'b00: r = {2'b00, a} + {2'b00, b};
      2'b01: r = {2'b00, a} - {2'b00, b};
      2'b10: r = prod[RES_W-1:0];
      2'b11: begin
        if (b == '0) dz = 1'b1;
        else         r  = {2'b00, a % b};
      end
    endcase
    return {r, (r == '0), dz};
  endfunction

  // A single valid requester always wins. For a conflict, the fixed build
  // favours requester 0; otherwise the winner is the requester that did not
  // win last time.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      grant = 1'b0;
`else
      grant = ~last_p0;
`endif
    end
  end

  assign accept    = (state == IDLE) && (req_valid != 2'b00);
  // Gating with rst_n keeps req_ready low while reset is held, even when
  // requests are pending.
  assign req_ready = (accept && rst_n) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state == RESP) ? (gnt_p0 ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);
  assign alu_out   = alu_calc(num1_p0, num2_p0, sel_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_p0     <= 1'b0;
      num1_p0    <= '0;
      num2_p0    <= '0;
      sel_p0     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_divz   <= 1'b0;
      op_count   <= '0;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_p0    <= 1'b1;
`endif
    end else begin
      unique case (state)
        // p0: latch the winner and its operands
        IDLE: begin
          if (accept) begin
            gnt_p0  <= grant;
            num1_p0 <= grant ? req1_num1 : req0_num1;
            num2_p0 <= grant ? req1_num2 : req0_num2;
            sel_p0  <= grant ? req1_sel  : req0_sel;
`ifndef ALU_ARB_FIXED_PRI_EN
            last_p0 <= grant;
`endif
            state   <= EXEC;
          end
        end
        // p1: ALU on latched operands into the response registers
        EXEC: begin
          {rsp_result, rsp_zero, rsp_divz} <= alu_out;
          state <= RESP;
        end
        // response hold: only the granted requester's ready completes it
        RESP: begin
          if (rsp_ready[gnt_p0]) begin
            op_count <= op_count + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
